// File: rtl/shared_imm_gen_ctrl.sv
// Two-requester immediate generator: round-robin arbitration into one shared
// decode/extend path, with a one-entry EMPTY/FULL response register.
module shared_imm_gen_ctrl (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        ReqA_Valid,
   input  logic [31:0] ReqA_Instr,
   output logic        ReqA_Ready,
   input  logic        ReqB_Valid,
   input  logic [31:0] ReqB_Instr,
   output logic        ReqB_Ready,
   output logic        Rsp_Valid,
   input  logic        Rsp_Ready,
   output logic [63:0] Rsp_Imm,
   output logic [1:0]  Rsp_Type,
   output logic        Rsp_Src,
   output logic        Rsp_Illegal,
   output logic [15:0] GrantCntA,
   output logic [15:0] GrantCntB
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   localparam logic [1:0] TYPE_I   = 2'b00;
   localparam logic [1:0] TYPE_D   = 2'b01;
   localparam logic [1:0] TYPE_B   = 2'b10;
   localparam logic [1:0] TYPE_CBZ = 2'b11;

   state_t      state_q, state_d;
   logic [63:0] imm_q, imm_d;
   logic [1:0]  type_q, type_d;
   logic        src_q, src_d;
   logic        illegal_q, illegal_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] cnt_a_q, cnt_a_d;
   logic [15:0] cnt_b_q, cnt_b_d;

   logic        rsp_hs;
   logic        can_accept;
   logic        grant_b;
   logic        xfer_a, xfer_b, xfer;
   logic [31:0] sel_instr;
   logic [63:0] dec_imm;
   logic [1:0]  dec_type;
   logic        dec_illegal;

   // With both valid, the requester that did not win last time goes next.
   assign grant_b    = (ReqA_Valid && ReqB_Valid) ? ~last_grant_q : ReqB_Valid;
   assign rsp_hs     = (state_q == S_FULL) && Rsp_Ready;
   assign can_accept = ~Reset && ((state_q == S_EMPTY) || rsp_hs);
   assign ReqA_Ready = can_accept && ~grant_b;
   assign ReqB_Ready = can_accept && grant_b;
   assign xfer_a     = ReqA_Valid && ReqA_Ready;
   assign xfer_b     = ReqB_Valid && ReqB_Ready;
   assign xfer       = xfer_a || xfer_b;
   assign sel_instr  = grant_b ? ReqB_Instr : ReqA_Instr;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      dec_imm     = 64'd0;
      dec_type    = TYPE_I;
      dec_illegal = 1'b0;
      if (sel_instr[31:26] == 6'b000101) begin
         dec_imm  = {{36{sel_instr[25]}}, sel_instr[25:0], 2'b00};
         dec_type = TYPE_B;
      end else if (sel_instr[31:24] == 8'b1011_0100) begin
         dec_imm  = {{43{sel_instr[23]}}, sel_instr[23:5], 2'b00};
         dec_type = TYPE_CBZ;
      end else if (sel_instr[31:21] == 11'b11111000010 ||
                   sel_instr[31:21] == 11'b11111000000) begin
         dec_imm  = {{55{sel_instr[20]}}, sel_instr[20:12]};
         dec_type = TYPE_D;
      end else if (sel_instr[31:22] inside {10'b1001000100, 10'b1011000100,
                                            10'b1101000100, 10'b1111000100,
                                            10'b1001001000, 10'b1011001000,
                                            10'b1101001000}) begin
         dec_imm  = {52'd0, sel_instr[21:10]};
         dec_type = TYPE_I;
      end else begin
         dec_illegal = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      imm_d        = imm_q;
      type_d       = type_q;
      src_d        = src_q;
      illegal_d    = illegal_q;
      last_grant_d = last_grant_q;
      cnt_a_d      = cnt_a_q;
      cnt_b_d      = cnt_b_q;
      if (xfer) begin
         state_d      = S_FULL;
         imm_d        = dec_imm;
         type_d       = dec_type;
         src_d        = xfer_b;
         illegal_d    = dec_illegal;
         last_grant_d = xfer_b;
         if (xfer_a && cnt_a_q != 16'hFFFF) cnt_a_d = cnt_a_q + 16'd1;
         if (xfer_b && cnt_b_q != 16'hFFFF) cnt_b_d = cnt_b_q + 16'd1;
      end else if (rsp_hs) begin
         state_d = S_EMPTY;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= S_EMPTY;
         imm_q        <= 64'd0;
         type_q       <= TYPE_I;
         src_q        <= 1'b0;
         illegal_q    <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_a_q      <= 16'd0;
         cnt_b_q      <= 16'd0;
      end else begin
         state_q      <= state_d;
         imm_q        <= imm_d;
         type_q       <= type_d;
         src_q        <= src_d;
         illegal_q    <= illegal_d;
         last_grant_q <= last_grant_d;
         cnt_a_q      <= cnt_a_d;
         cnt_b_q      <= cnt_b_d;
      end
   end

   assign Rsp_Valid   = (state_q == S_FULL);
   assign Rsp_Imm     = imm_q;
   assign Rsp_Type    = type_q;
   assign Rsp_Src     = src_q;
   assign Rsp_Illegal = illegal_q;
   assign GrantCntA   = cnt_a_q;
   assign GrantCntB   = cnt_b_q;

endmodule

// File: tb/tb_shared_imm_gen_ctrl.sv
// Self-checking bench for shared_imm_gen_ctrl: table-driven decode vectors,
// directed multi-cycle sequences, and a queue scoreboard fed by observed transfers.
module tb_shared_imm_gen_ctrl;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        ReqA_Valid, ReqB_Valid;
   logic [31:0] ReqA_Instr, ReqB_Instr;
   logic        ReqA_Ready, ReqB_Ready;
   logic        Rsp_Valid, Rsp_Ready;
   logic [63:0] Rsp_Imm;
   logic [1:0]  Rsp_Type;
   logic        Rsp_Src, Rsp_Illegal;
   logic [15:0] GrantCntA, GrantCntB;

   shared_imm_gen_ctrl dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .ReqA_Valid (ReqA_Valid),
      .ReqA_Instr (ReqA_Instr),
      .ReqA_Ready (ReqA_Ready),
      .ReqB_Valid (ReqB_Valid),
      .ReqB_Instr (ReqB_Instr),
      .ReqB_Ready (ReqB_Ready),
      .Rsp_Valid  (Rsp_Valid),
      .Rsp_Ready  (Rsp_Ready),
      .Rsp_Imm    (Rsp_Imm),
      .Rsp_Type   (Rsp_Type),
      .Rsp_Src    (Rsp_Src),
      .Rsp_Illegal(Rsp_Illegal),
      .GrantCntA  (GrantCntA),
      .GrantCntB  (GrantCntB)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] imm;
      logic [1:0]  typ;
      logic        ill;
      logic        src;
   } rsp_t;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] imm;
      logic [1:0]  typ;
      logic        ill;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   rsp_t sb_q[$];
   logic [15:0] mdl_cnt_a = 16'd0;
   logic [15:0] mdl_cnt_b = 16'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference decoder written with signed arithmetic rather than bit concatenation.
   function automatic rsp_t model(input logic [31:0] i);
      rsp_t   m;
      longint v;
      m.imm = 64'd0;
      m.typ = 2'b00;
      m.ill = 1'b0;
      m.src = 1'b0;
      if (i[31:26] == 6'b000101) begin
         v = $signed(i[25:0]);
         m.imm = 64'(v * 4);
         m.typ = 2'b10;
      end else if (i[31:24] == 8'hB4) begin
         v = $signed(i[23:5]);
         m.imm = 64'(v * 4);
         m.typ = 2'b11;
      end else if (i[31:21] == 11'h7C2 || i[31:21] == 11'h7C0) begin
         v = $signed(i[20:12]);
         m.imm = 64'(v);
         m.typ = 2'b01;
      end else if (i[31:22] inside {10'h244, 10'h2C4, 10'h344, 10'h3C4,
                                    10'h248, 10'h2C8, 10'h348}) begin
         m.imm = 64'(i[21:10]);
      end else begin
         m.ill = 1'b1;
      end
      return m;
   endfunction

   // Scoreboard monitor, sampled on the falling edge away from the active edge.
   always @(negedge CLK) begin
      rsp_t e;
      check("cnt_a_model", 64'(GrantCntA), 64'(mdl_cnt_a));
      check("cnt_b_model", 64'(GrantCntB), 64'(mdl_cnt_b));
      check("one_grant", 64'(ReqA_Ready & ReqB_Ready), 64'd0);
      if (Reset) begin
         check("rst_ready_a", 64'(ReqA_Ready), 64'd0);
         check("rst_ready_b", 64'(ReqB_Ready), 64'd0);
         sb_q.delete();
         mdl_cnt_a = 16'd0;
         mdl_cnt_b = 16'd0;
      end else begin
         if (Rsp_Valid && Rsp_Ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_rsp", 64'(Rsp_Valid), 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("sb_imm", Rsp_Imm, e.imm);
               check("sb_type", 64'(Rsp_Type), 64'(e.typ));
               check("sb_illegal", 64'(Rsp_Illegal), 64'(e.ill));
               check("sb_src", 64'(Rsp_Src), 64'(e.src));
            end
         end
         if (ReqA_Valid && ReqA_Ready) begin
            e = model(ReqA_Instr);
            e.src = 1'b0;
            sb_q.push_back(e);
            if (mdl_cnt_a != 16'hFFFF) mdl_cnt_a = mdl_cnt_a + 16'd1;
         end
         if (ReqB_Valid && ReqB_Ready) begin
            e = model(ReqB_Instr);
            e.src = 1'b1;
            sb_q.push_back(e);
            if (mdl_cnt_b != 16'hFFFF) mdl_cnt_b = mdl_cnt_b + 16'd1;
         end
      end
   end

   initial begin
      vec_t        vecs[12];
      logic [63:0] hold_imm;
      logic [1:0]  hold_type;
      logic        hold_src, hold_ill;
      logic        use_b;

      vecs[0]  = '{32'h91002820, 64'h000000000000000A, 2'b00, 1'b0};
      vecs[1]  = '{32'hF8410020, 64'h0000000000000010, 2'b01, 1'b0};
      vecs[2]  = '{32'hF85F0020, 64'hFFFFFFFFFFFFFFF0, 2'b01, 1'b0};
      vecs[3]  = '{32'h00000000, 64'h0000000000000000, 2'b00, 1'b1};
      vecs[4]  = '{32'h17FFFFFF, 64'hFFFFFFFFFFFFFFFC, 2'b10, 1'b0};
      vecs[5]  = '{32'hB4000040, 64'h0000000000000008, 2'b11, 1'b0};
      vecs[6]  = '{32'h14000001, 64'h0000000000000004, 2'b10, 1'b0};
      vecs[7]  = '{32'hB5000040, 64'h0000000000000000, 2'b00, 1'b1};
      vecs[8]  = '{32'hF1000400, 64'h0000000000000001, 2'b00, 1'b0};
      vecs[9]  = '{32'hD23FFC00, 64'h0000000000000FFF, 2'b00, 1'b0};
      vecs[10] = '{32'hF8000000, 64'h0000000000000000, 2'b01, 1'b0};
      vecs[11] = '{32'hB4FFFFE0, 64'hFFFFFFFFFFFFFFFC, 2'b11, 1'b0};

      // Reset with both requesters valid: no ready may leak out.
      Reset      = 1'b1;
      ReqA_Valid = 1'b1;
      ReqB_Valid = 1'b1;
      ReqA_Instr = 32'h91002820;
      ReqB_Instr = 32'hB4000040;
      Rsp_Ready  = 1'b0;
      #1;
      check("reset_ready_a", 64'(ReqA_Ready), 64'd0);
      check("reset_ready_b", 64'(ReqB_Ready), 64'd0);
      step();
      step();
      check("reset_rsp_valid", 64'(Rsp_Valid), 64'd0);
      check("reset_rsp_imm", Rsp_Imm, 64'd0);
      check("reset_rsp_type", 64'(Rsp_Type), 64'd0);
      check("reset_rsp_src", 64'(Rsp_Src), 64'd0);
      check("reset_rsp_illegal", 64'(Rsp_Illegal), 64'd0);
      check("reset_cnt_a", 64'(GrantCntA), 64'd0);
      check("reset_cnt_b", 64'(GrantCntB), 64'd0);
      ReqA_Valid = 1'b0;
      ReqB_Valid = 1'b0;
      Reset      = 1'b0;
      Rsp_Ready  = 1'b1;
      step();

      // Decode table, alternating the requester that presents each word.
      for (int i = 0; i < 12; i++) begin
         use_b = 1'(i % 2);
         ReqA_Valid = ~use_b;
         ReqB_Valid = use_b;
         ReqA_Instr = vecs[i].instr;
         ReqB_Instr = vecs[i].instr;
         step();
         ReqA_Valid = 1'b0;
         ReqB_Valid = 1'b0;
         check($sformatf("vec%0d_valid", i), 64'(Rsp_Valid), 64'd1);
         check($sformatf("vec%0d_imm", i), Rsp_Imm, vecs[i].imm);
         check($sformatf("vec%0d_type", i), 64'(Rsp_Type), 64'(vecs[i].typ));
         check($sformatf("vec%0d_illegal", i), 64'(Rsp_Illegal), 64'(vecs[i].ill));
         check($sformatf("vec%0d_src", i), 64'(Rsp_Src), 64'(use_b));
         step();
      end
      check("table_drained", 64'(Rsp_Valid), 64'd0);

      // Round-robin from reset: A wins the first tie, then strict alternation.
      Reset = 1'b1;
      step();
      Reset      = 1'b0;
      ReqA_Valid = 1'b1;
      ReqB_Valid = 1'b1;
      ReqA_Instr = 32'h17FFFFFF;
      ReqB_Instr = 32'hB4000040;
      #1;
      check("rr_first_ready_a", 64'(ReqA_Ready), 64'd1);
      check("rr_first_ready_b", 64'(ReqB_Ready), 64'd0);
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("rr%0d_valid", k), 64'(Rsp_Valid), 64'd1);
         check($sformatf("rr%0d_src", k), 64'(Rsp_Src), 64'((k - 1) % 2));
         check($sformatf("rr%0d_imm", k), Rsp_Imm,
               ((k - 1) % 2 == 0) ? 64'hFFFFFFFFFFFFFFFC : 64'h0000000000000008);
      end
      ReqA_Valid = 1'b0;
      ReqB_Valid = 1'b0;
      step();
      step();

      // Back-pressure: held response stays put, then handshake and accept together.
      Rsp_Ready  = 1'b0;
      ReqA_Valid = 1'b1;
      ReqA_Instr = 32'h91002820;
      step();
      ReqB_Valid = 1'b1;
      ReqA_Instr = 32'hF85F0020;
      hold_imm  = Rsp_Imm;
      hold_type = Rsp_Type;
      hold_src  = Rsp_Src;
      hold_ill  = Rsp_Illegal;
      check("stall_loaded_imm", hold_imm, 64'h000000000000000A);
      for (int s = 0; s < 5; s++) begin
         #1;
         check($sformatf("stall%0d_ready_a", s), 64'(ReqA_Ready), 64'd0);
         check($sformatf("stall%0d_ready_b", s), 64'(ReqB_Ready), 64'd0);
         step();
         check($sformatf("stall%0d_valid", s), 64'(Rsp_Valid), 64'd1);
         check($sformatf("stall%0d_imm", s), Rsp_Imm, hold_imm);
         check($sformatf("stall%0d_type", s), 64'(Rsp_Type), 64'(hold_type));
         check($sformatf("stall%0d_src", s), 64'(Rsp_Src), 64'(hold_src));
         check($sformatf("stall%0d_illegal", s), 64'(Rsp_Illegal), 64'(hold_ill));
      end
      ReqB_Valid = 1'b0;
      ReqA_Instr = 32'hF8410020;
      Rsp_Ready  = 1'b1;
      #1;
      check("unstall_ready_a", 64'(ReqA_Ready), 64'd1);
      step();
      ReqA_Valid = 1'b0;
      check("unstall_valid", 64'(Rsp_Valid), 64'd1);
      check("unstall_imm", Rsp_Imm, 64'h0000000000000010);
      check("unstall_type", 64'(Rsp_Type), 64'd1);
      step();

      // Reset while FULL drops the held response.
      Rsp_Ready  = 1'b0;
      ReqA_Valid = 1'b1;
      ReqA_Instr = 32'h91002820;
      step();
      ReqA_Valid = 1'b0;
      check("pre_reset_full", 64'(Rsp_Valid), 64'd1);
      Reset = 1'b1;
      step();
      check("midreset_valid", 64'(Rsp_Valid), 64'd0);
      check("midreset_imm", Rsp_Imm, 64'd0);
      check("midreset_cnt_a", 64'(GrantCntA), 64'd0);
      check("midreset_cnt_b", 64'(GrantCntB), 64'd0);
      Reset     = 1'b0;
      Rsp_Ready = 1'b1;
      step();
      check("post_reset_no_rsp", 64'(Rsp_Valid), 64'd0);

      // Saturation of GrantCntA after 0xFFFF back-to-back transfers.
      ReqA_Valid = 1'b1;
      ReqA_Instr = 32'hF1000400;
      repeat (16'hFFFF) step();
      check("sat_cnt_a_full", 64'(GrantCntA), 64'hFFFF);
      step();
      check("sat_cnt_a_hold", 64'(GrantCntA), 64'hFFFF);
      check("sat_cnt_b", 64'(GrantCntB), 64'd0);
      ReqA_Valid = 1'b0;
      step();
      step();
      check("final_empty", 64'(Rsp_Valid), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shared_imm_gen_ctrl.md
SHARED_IMM_GEN_CTRL -- requirements
Module: shared_imm_gen_ctrl

Interface
REQ-001 The block SHALL have ports: CLK  input  1  rising-edge clock, sole clock domain.
REQ-002 The block SHALL have ports: Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-003 The block SHALL have ports: ReqA_Valid  input  1  requester A (decode stage) has an instruction.
REQ-004 The block SHALL have ports: ReqA_Instr  input  32  requester A instruction word.
REQ-005 The block SHALL have ports: ReqA_Ready  output  1  requester A instruction accepted this cycle.
REQ-006 The block SHALL have ports: ReqB_Valid / ReqB_Instr / ReqB_Ready  input 1 / input 32 / output 1  requester B (branch predictor), same meanings as A.
REQ-007 The block SHALL have ports: Rsp_Valid  output  1  response register holds a result.
REQ-008 The block SHALL have ports: Rsp_Ready  input  1  consumer takes the response this cycle.
REQ-009 The block SHALL have ports: Rsp_Imm  output  64  extended immediate.
REQ-010 The block SHALL have ports: Rsp_Type  output  2  00 I-type, 01 D-type, 10 B, 11 CBZ.
REQ-011 The block SHALL have ports: Rsp_Src  output  1  0 = requester A, 1 = requester B.
REQ-012 The block SHALL have ports: Rsp_Illegal  output  1  opcode matched no supported format.
REQ-013 The block SHALL have ports: GrantCntA, GrantCntB  output  16 each  saturating accept counters.

Function
REQ-014 Decode SHALL be fixed: B if Instr[31:26]=000101; CBZ if Instr[31:24]=10110100; D if Instr[31:21] in {11111000010, 11111000000}; I if Instr[31:22] in {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1011001000, 1101001000}; else illegal. Priority order: B, CBZ, D, I.
REQ-015 Extension SHALL be: I -> {52 zeros, Instr[21:10]}; D -> sign-extend Instr[20:12] to 64; B -> sign-extend {Instr[25:0], 00}; CBZ -> sign-extend {Instr[23:5], 00}.
REQ-016 An illegal instruction SHALL return Rsp_Imm=0, Rsp_Type=00, Rsp_Illegal=1.
REQ-017 A single shared decode/extend path SHALL be used; only the granted requester's Instr SHALL drive it.
REQ-018 The block SHALL be a two-state machine: EMPTY (Rsp_Valid=0) and FULL (Rsp_Valid=1), with a one-entry response register.
REQ-019 CanAccept SHALL equal (state==EMPTY) or (Rsp_Valid and Rsp_Ready); full throughput of one result per cycle SHALL be achieved.
REQ-020 Arbitration SHALL be round-robin using a LastGrant bit: with only one requester valid, that requester is granted; with both valid, the requester not equal to LastGrant is granted.
REQ-021 ReqX_Ready SHALL be (CanAccept and granted==X), and SHALL be 0 for the non-granted requester.
REQ-022 A transfer SHALL occur on ReqX_Valid and ReqX_Ready; at the next edge the response register loads the result, Rsp_Src=X, LastGrant=X, and GrantCntX increments, saturating at 0xFFFF.
REQ-023 Latency SHALL be one cycle: accept at edge N yields Rsp_Valid=1 after edge N+1.
REQ-024 Transitions SHALL be: EMPTY->FULL on a transfer; FULL->EMPTY on a response handshake with no transfer; FULL->FULL on handshake plus transfer (new data) or on no handshake (hold).
REQ-025 While FULL and Rsp_Ready=0, all Rsp_* outputs SHALL hold stable.
REQ-026 LastGrant SHALL update only on a transfer; an idle cycle SHALL not change priority.
REQ-027 A requester SHALL never wait more than one transfer while continuously valid.

Reset
REQ-028 While Reset=1 at an edge, the block SHALL set state=EMPTY, Rsp_Valid=0, Rsp_Imm=0, Rsp_Type=00, Rsp_Src=0, Rsp_Illegal=0, LastGrant=1 (A wins first tie), and GrantCntA=GrantCntB=0.
REQ-029 During Reset, ReqA_Ready and ReqB_Ready SHALL be 0.
REQ-030 Reset mid-operation SHALL drop any held response without it being presented.

Verification
REQ-031 A only, Instr=0x91002820, Rsp_Ready=1 -> the next cycle gives Rsp_Imm=0x000000000000000A, Type=00, Src=0.
REQ-032 Both valid continuously, A=0x17FFFFFF (B), B=0xB4000040 (CBZ), Rsp_Ready=1 -> responses alternate Src=0,1,0,1; Imm alternates 0xFFFFFFFFFFFFFFFC and 0x0000000000000008.
REQ-033 D-type 0xF8410020 then 0xF85F0020 -> Imm=0x10 then 0xFFFFFFFFFFFFFFF0, Type=01.
REQ-034 Rsp_Ready=0 for 5 cycles while FULL -> outputs stable, both Ready=0; Rsp_Ready=1 with A valid -> handshake and new accept in the same cycle.
REQ-035 Instr=0x00000000 -> Rsp_Illegal=1, Imm=0; Reset asserted while FULL -> Rsp_Valid=0 next cycle; counters 0.
REQ-036 Force GrantCntA to 0xFFFF (0xFFFF transfers from A) -> one more transfer leaves it at 0xFFFF.
